// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and a valid/ack byte holding register.
//
// State table:
//   state   | meaning
//   IDLE    | line idle, waiting for a falling edge on rx_s
//   START   | counting to the middle of the start bit to confirm it
//   DATA    | sampling 8 data bits, LSB first, one per bit period
//   STOP    | sampling the stop bit; high completes the byte, low is a framing error
//   BREAK   | line held low after a framing error; wait for it to return high
//
// Ports:
//   clk_125MHz  in   system clock, the only clock
//   rst         in   asynchronous active-high reset
//   rx          in   serial line (asynchronous, idles high)
//   rx_d        out  received byte, valid while rx_valid is high
//   rx_valid    out  byte available, held until rx_ack
//   rx_ack      in   consumer accepts the byte (only effective while rx_valid)
//   frame_err   out  one-cycle pulse when the stop bit is sampled low
//   overrun     out  one-cycle pulse when a byte completes while the previous one is unacknowledged
//   busy        out  high whenever the receiver is not in IDLE
module uart_rx #(
  parameter int CLK_PER_BIT = 1086,
  parameter int HALF_BIT    = CLK_PER_BIT / 2
) (
  input  logic       clk_125MHz,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_d,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [15:0] HALF_LIM = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_LIM  = 16'(CLK_PER_BIT - 1);

  logic        rx_meta_q, rx_s_q;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        byte_done;

  // Two-flop synchronizer; resets to the idle (high) line level so a reset
  // never looks like a start edge.
  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_125MHz or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LIM) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            // start bit gone by mid-bit: treat as a glitch
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LIM) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LIM) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        // a held-low line must not decode as a stream of 0x00 frames
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    // An ack in the completion cycle frees the register for the new byte.
    if (byte_done) begin
      if (!valid_q || rx_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rx_ack && valid_q) begin
      valid_d = 1'b0;
    end
  end

  assign rx_d      = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Expected bytes are queued as
// frames are driven and popped when the receiver delivers a byte. A shorter
// bit period than the default keeps the run time small; the glitch length is
// scaled to stay below half a bit.
module tb_uart_rx;
  localparam int C   = 260;
  localparam int H   = C / 2;
  localparam int LAT = H + 9 * C + 3;  // rx driven low (negedge) -> rx_valid seen (negedge)

  logic       clk_125MHz = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_d;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int deliv_cnt = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;
  int last_deliv_cyc = 0;
  int t_start  = 0;
  int req_ack_cyc = -1;
  bit auto_ack = 1'b0;
  bit allow_garbage = 1'b0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLK_PER_BIT(C)) dut (
    .clk_125MHz(clk_125MHz),
    .rst       (rst),
    .rx        (rx),
    .rx_d      (rx_d),
    .rx_valid  (rx_valid),
    .rx_ack    (rx_ack),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial forever #4 clk_125MHz = ~clk_125MHz;

  initial forever begin
    @(posedge clk_125MHz);
    cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Delivery monitor: a delivery is rx_valid rising, or rx_d changing while
  // rx_valid stays high (ack taken in the completion cycle).
  initial begin
    logic       pv;
    logic [7:0] pd;
    pv = 1'b0;
    pd = 8'h00;
    forever begin
      @(negedge clk_125MHz);
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && (!pv || rx_d != pd)) begin
        deliv_cnt++;
        last_deliv_cyc = cyc;
        if (exp_q.size() != 0) begin
          check_eq("rx_d", 32'(rx_d), 32'(exp_q.pop_front()));
        end else if (allow_garbage) begin
          check_eq("no_false_c3", 32'(rx_d == 8'hC3), 32'd0);
        end else begin
          check_eq("byte_expected", 32'(exp_q.size()), 32'd1);
        end
      end
      pv = rx_valid;
      pd = rx_d;
    end
  end

  // Sole driver of rx_ack: automatic ack 10 cycles after rx_valid, or a
  // one-shot ack requested for a given cycle.
  initial begin
    bit ack_armed;
    bit ack_pending;
    int ack_wait;
    ack_armed   = 1'b0;
    ack_pending = 1'b0;
    ack_wait    = 0;
    rx_ack      = 1'b0;
    forever begin
      @(negedge clk_125MHz);
      rx_ack = 1'b0;
      if (ack_pending) begin
        check_eq("valid_clr_after_ack", 32'(rx_valid), 32'd0);
        ack_pending = 1'b0;
      end
      if (ack_armed) begin
        ack_wait--;
        if (ack_wait == 0) begin
          rx_ack      = 1'b1;
          ack_armed   = 1'b0;
          ack_pending = 1'b1;
        end
      end else if (auto_ack && rx_valid) begin
        ack_armed = 1'b1;
        ack_wait  = 9;
      end
      if (req_ack_cyc == cyc) rx_ack = 1'b1;
    end
  end

  initial begin
    #(8 * 200000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called on a negedge; returns on a negedge after the stop bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit ack_at_done);
    t_start = cyc;
    if (ack_at_done) req_ack_cyc = cyc + LAT - 1;
    rx = 1'b0;
    repeat (C) @(negedge clk_125MHz);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk_125MHz);
    end
    rx = stop_bit;
    repeat (C) @(negedge clk_125MHz);
  endtask

  task automatic wait_deliv(input int target);
    int n;
    n = 0;
    while (deliv_cnt < target && n < 2 * C) begin
      @(negedge clk_125MHz);
      n++;
    end
    check_eq("deliv_timeout", 32'(deliv_cnt >= target), 32'd1);
  endtask

  initial begin
    int d0, fe0, ov0;
    logic [7:0] c3;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk_125MHz);
    check_eq("rst_rx_d", 32'(rx_d), 32'd0);
    check_eq("rst_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk_125MHz);

    // 1: single byte, latency from the start edge
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1, 1'b0);
    wait_deliv(1);
    check_eq("latency", 32'(last_deliv_cyc - t_start), 32'(LAT));
    check_eq("t1_no_fe", 32'(fe_cnt), 32'd0);
    check_eq("t1_no_ov", 32'(ov_cnt), 32'd0);
    repeat (10) @(negedge clk_125MHz);

    // 2: back-to-back frames, each acked 10 cycles after rx_valid
    auto_ack = 1'b1;
    repeat (20) @(negedge clk_125MHz);
    d0 = deliv_cnt;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_byte(8'hA5, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    wait_deliv(d0 + 2);
    repeat (20) @(negedge clk_125MHz);
    auto_ack = 1'b0;
    check_eq("t2_valid_idle", 32'(rx_valid), 32'd0);

    // ack while nothing is held is ignored
    req_ack_cyc = cyc + 1;
    repeat (3) @(negedge clk_125MHz);
    check_eq("ack_ignored", 32'(rx_valid), 32'd0);

    // 3: short low glitch is rejected
    d0 = deliv_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    rx = 1'b0;
    repeat (50) @(negedge clk_125MHz);
    check_eq("glitch_busy", 32'(busy), 32'd1);
    repeat (50) @(negedge clk_125MHz);
    rx = 1'b1;
    repeat (60) @(negedge clk_125MHz);
    check_eq("glitch_idle", 32'(busy), 32'd0);
    check_eq("glitch_no_byte", 32'(deliv_cnt - d0), 32'd0);
    check_eq("glitch_no_fe", 32'(fe_cnt - fe0), 32'd0);
    check_eq("glitch_no_ov", 32'(ov_cnt - ov0), 32'd0);

    // 4: framing error, line held low, then recovery
    d0 = deliv_cnt; fe0 = fe_cnt;
    send_byte(8'hFF, 1'b0, 1'b0);
    repeat (5 * C) @(negedge clk_125MHz);
    check_eq("fe_pulses", 32'(fe_cnt - fe0), 32'd1);
    check_eq("fe_no_valid", 32'(rx_valid), 32'd0);
    check_eq("fe_no_byte", 32'(deliv_cnt - d0), 32'd0);
    check_eq("break_busy", 32'(busy), 32'd1);
    rx = 1'b1;
    repeat (10) @(negedge clk_125MHz);
    check_eq("break_released", 32'(busy), 32'd0);
    repeat (C) @(negedge clk_125MHz);
    auto_ack = 1'b1;
    exp_q.push_back(8'h12);
    send_byte(8'h12, 1'b1, 1'b0);
    wait_deliv(d0 + 1);
    repeat (20) @(negedge clk_125MHz);
    auto_ack = 1'b0;

    // 5: overrun, then ack exactly in the completion cycle
    d0 = deliv_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'h01);
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h02, 1'b1, 1'b0);
    repeat (5) @(negedge clk_125MHz);
    check_eq("ov_pulses", 32'(ov_cnt - ov0), 32'd1);
    check_eq("ov_keeps_d", 32'(rx_d), 32'h01);
    check_eq("ov_keeps_valid", 32'(rx_valid), 32'd1);
    exp_q.push_back(8'h03);
    send_byte(8'h03, 1'b1, 1'b1);
    wait_deliv(d0 + 2);
    check_eq("ack_done_d", 32'(rx_d), 32'h03);
    check_eq("ack_done_valid", 32'(rx_valid), 32'd1);
    check_eq("ack_done_no_ov", 32'(ov_cnt - ov0), 32'd1);

    // 6: reset in the middle of data bit 4 of 0xC3
    c3 = 8'hC3;
    rx = 1'b0;
    repeat (C) @(negedge clk_125MHz);
    for (int i = 0; i < 4; i++) begin
      rx = c3[i];
      repeat (C) @(negedge clk_125MHz);
    end
    rx = c3[4];
    repeat (C / 2) @(negedge clk_125MHz);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_rx_d", 32'(rx_d), 32'd0);
    check_eq("mid_rst_valid", 32'(rx_valid), 32'd0);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_fe", 32'(frame_err), 32'd0);
    check_eq("mid_rst_ov", 32'(overrun), 32'd0);
    repeat (3) @(negedge clk_125MHz);
    rst = 1'b0;
    allow_garbage = 1'b1;
    auto_ack = 1'b1;
    repeat (C / 2 - 3) @(negedge clk_125MHz);
    for (int i = 5; i < 8; i++) begin
      rx = c3[i];
      repeat (C) @(negedge clk_125MHz);
    end
    rx = 1'b1;
    repeat (12 * C) @(negedge clk_125MHz);
    allow_garbage = 1'b0;
    check_eq("post_rst_idle", 32'(busy), 32'd0);
    d0 = deliv_cnt;
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1, 1'b0);
    wait_deliv(d0 + 1);
    repeat (20) @(negedge clk_125MHz);
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
